// File: rtl/edca_ac_arbiter.sv
// EDCA access-category arbiter: picks one expired AC with data at each early-slot tick,
// grants it to the macController and pulses an internal collision to every losing AC.
module edca_ac_arbiter #(
  parameter int NUM_AC      = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              macCoreClk,
  input  logic              macCoreClkSoftRst,
  input  logic              arbEnable,
  input  logic [NUM_AC-1:0] backoffDone,
  input  logic [NUM_AC-1:0] acHasData,
  input  logic              tickDMAEarlySlot_p,
  input  logic              txAck_p,
  input  logic              txEnd_p,
  output logic              txReq,
  output logic [1:0]        txAc,
  output logic [NUM_AC-1:0] internalColl_p,
  output logic              grantTimeout_p,
  output logic [1:0]        arbCs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    TX    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic [NUM_AC-1:0] cand_s;
  logic [1:0]        winner_s;
  logic [NUM_AC-1:0] winner_mask_s;
  logic [NUM_AC-1:0] txac_mask_s;
  logic              busy_s;

  // Highest set index wins: index NUM_AC-1 is the highest-priority AC.
  function automatic logic [1:0] highest_idx(input logic [NUM_AC-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_AC; i++) begin
      if (v[i]) begin
        idx = i[1:0];
      end
    end
    return idx;
  endfunction

  // Candidate set, winner selection and one-hot masks for winner and granted AC.
  always_comb begin
    cand_s        = backoffDone & acHasData;
    winner_s      = highest_idx(cand_s);
    winner_mask_s = '0;
    txac_mask_s   = '0;
    for (int i = 0; i < NUM_AC; i++) begin
      winner_mask_s[i] = (winner_s == i[1:0]);
      txac_mask_s[i]   = (txAc == i[1:0]);
    end
    busy_s = ~backoffDone[txAc];
  end

  // Arbitration FSM with registered grant, pulse and timeout outputs.
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkSoftRst) begin
      state_r        <= IDLE;
      txReq          <= 1'b0;
      txAc           <= 2'd0;
      internalColl_p <= '0;
      grantTimeout_p <= 1'b0;
      cnt_r          <= 8'd0;
    end else if (!arbEnable) begin
      state_r        <= IDLE;
      txReq          <= 1'b0;
      internalColl_p <= '0;
      grantTimeout_p <= 1'b0;
      cnt_r          <= 8'd0;
    end else begin
      internalColl_p <= '0;
      grantTimeout_p <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= ARB;
        end
        ARB: begin
          if (tickDMAEarlySlot_p && (cand_s != '0)) begin
            state_r        <= GRANT;
            txAc           <= winner_s;
            txReq          <= 1'b1;
            internalColl_p <= cand_s & ~winner_mask_s;
            cnt_r          <= 8'd0;
          end
        end
        GRANT: begin
          // Ack beats medium-busy, which beats the timeout.
          if (txAck_p) begin
            state_r <= TX;
            txReq   <= 1'b0;
          end else if (busy_s) begin
            state_r <= ARB;
            txReq   <= 1'b0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r        <= ARB;
            txReq          <= 1'b0;
            grantTimeout_p <= 1'b1;
            internalColl_p <= txac_mask_s;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        TX: begin
          if (txEnd_p) begin
            state_r <= ARB;
          end
        end
        default: begin
          state_r <= IDLE;
          txReq   <= 1'b0;
        end
      endcase
    end
  end

  assign arbCs = state_r;

endmodule

// File: tb/tb_edca_ac_arbiter.sv
// Directed self-checking bench for edca_ac_arbiter; expected values are hand-derived.
module tb_edca_ac_arbiter;

  logic       clk;
  logic       rst;
  logic       arb_enable;
  logic [3:0] backoff_done;
  logic [3:0] ac_has_data;
  logic       tick;
  logic       tx_ack;
  logic       tx_end;
  logic       tx_req;
  logic [1:0] tx_ac;
  logic [3:0] int_coll;
  logic       grant_timeout;
  logic [1:0] arb_cs;

  int checks;
  int failures;

  edca_ac_arbiter #(.NUM_AC(4), .ACK_TIMEOUT(64)) dut (
    .macCoreClk         (clk),
    .macCoreClkSoftRst  (rst),
    .arbEnable          (arb_enable),
    .backoffDone        (backoff_done),
    .acHasData          (ac_has_data),
    .tickDMAEarlySlot_p (tick),
    .txAck_p            (tx_ack),
    .txEnd_p            (tx_end),
    .txReq              (tx_req),
    .txAc               (tx_ac),
    .internalColl_p     (int_coll),
    .grantTimeout_p     (grant_timeout),
    .arbCs              (arb_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    arb_enable   = 1'b0;
    backoff_done = 4'b0000;
    ac_has_data  = 4'b0000;
    tick         = 1'b0;
    tx_ack       = 1'b0;
    tx_end       = 1'b0;
    step();
    step();
    check_val("rst_cs", 32'(arb_cs), 32'd0);
    check_val("rst_req", 32'(tx_req), 32'd0);
    check_val("rst_ac", 32'(tx_ac), 32'd0);
    check_val("rst_coll", 32'(int_coll), 32'd0);
    check_val("rst_to", 32'(grant_timeout), 32'd0);

    rst = 1'b0;
    arb_enable = 1'b1;
    step();
    check_val("idle_to_arb", 32'(arb_cs), 32'd1);

    // Single AC grant, ack, tick ignored in TX, end of TXOP
    backoff_done = 4'b0010; ac_has_data = 4'b0010; tick = 1'b1;
    step(); tick = 1'b0;
    check_val("single_req", 32'(tx_req), 32'd1);
    check_val("single_ac", 32'(tx_ac), 32'd1);
    check_val("single_coll", 32'(int_coll), 32'd0);
    check_val("single_cs", 32'(arb_cs), 32'd2);
    tx_ack = 1'b1;
    step(); tx_ack = 1'b0;
    check_val("ack_cs", 32'(arb_cs), 32'd3);
    check_val("ack_req", 32'(tx_req), 32'd0);
    tick = 1'b1;
    step(); tick = 1'b0;
    check_val("tx_tick_ign", 32'(arb_cs), 32'd3);
    check_val("tx_ac_hold", 32'(tx_ac), 32'd1);
    tx_end = 1'b1;
    step(); tx_end = 1'b0;
    check_val("end_cs", 32'(arb_cs), 32'd1);

    // Internal collision, then medium busy drops the grant
    backoff_done = 4'b1011; ac_has_data = 4'b1111; tick = 1'b1;
    step(); tick = 1'b0;
    check_val("coll_ac", 32'(tx_ac), 32'd3);
    check_val("coll_mask", 32'(int_coll), 32'h3);
    step();
    check_val("coll_once", 32'(int_coll), 32'd0);
    check_val("coll_stay", 32'(arb_cs), 32'd2);
    backoff_done = 4'b0011;
    step();
    check_val("busy_cs", 32'(arb_cs), 32'd1);
    check_val("busy_req", 32'(tx_req), 32'd0);
    check_val("busy_coll", 32'(int_coll), 32'd0);
    check_val("busy_to", 32'(grant_timeout), 32'd0);

    // No tick in ARB: nothing evaluated; then data gating
    backoff_done = 4'b1100; ac_has_data = 4'b0100;
    step();
    check_val("notick_cs", 32'(arb_cs), 32'd1);
    tick = 1'b1;
    step(); tick = 1'b0;
    check_val("gate_ac", 32'(tx_ac), 32'd2);
    check_val("gate_coll", 32'(int_coll), 32'd0);
    check_val("gate_req", 32'(tx_req), 32'd1);

    // Reset mid-GRANT
    rst = 1'b1;
    step(); rst = 1'b0;
    check_val("mrst_req", 32'(tx_req), 32'd0);
    check_val("mrst_cs", 32'(arb_cs), 32'd0);
    check_val("mrst_coll", 32'(int_coll), 32'd0);
    step();
    check_val("mrst_arb", 32'(arb_cs), 32'd1);

    // Timeout: grant AC0, never ack
    backoff_done = 4'b0001; ac_has_data = 4'b0001; tick = 1'b1;
    step(); tick = 1'b0;
    check_val("to_grant_ac", 32'(tx_ac), 32'd0);
    repeat (63) step();
    check_val("to_pre_cs", 32'(arb_cs), 32'd2);
    check_val("to_pre_pulse", 32'(grant_timeout), 32'd0);
    step();
    check_val("to_pulse", 32'(grant_timeout), 32'd1);
    check_val("to_coll", 32'(int_coll), 32'h1);
    check_val("to_cs", 32'(arb_cs), 32'd1);
    check_val("to_req", 32'(tx_req), 32'd0);
    step();
    check_val("to_once", 32'(grant_timeout), 32'd0);
    check_val("to_coll_once", 32'(int_coll), 32'd0);

    // Ack and busy in the same cycle: ack wins; disable in TX
    backoff_done = 4'b0100; ac_has_data = 4'b0100; tick = 1'b1;
    step(); tick = 1'b0;
    check_val("race_ac", 32'(tx_ac), 32'd2);
    tx_ack = 1'b1; backoff_done = 4'b0000;
    step(); tx_ack = 1'b0;
    check_val("race_cs", 32'(arb_cs), 32'd3);
    arb_enable = 1'b0;
    step();
    check_val("dis_cs", 32'(arb_cs), 32'd0);
    arb_enable = 1'b1;
    step();
    check_val("reen_cs", 32'(arb_cs), 32'd1);

    // Tick coinciding with a GRANT exit is not evaluated
    backoff_done = 4'b1000; ac_has_data = 4'b1000; tick = 1'b1;
    step(); tick = 1'b0;
    check_val("tx_grant_ac", 32'(tx_ac), 32'd3);
    backoff_done = 4'b0100; ac_has_data = 4'b0100; tick = 1'b1;
    step(); tick = 1'b0;
    check_val("exit_tick_cs", 32'(arb_cs), 32'd1);
    check_val("exit_tick_req", 32'(tx_req), 32'd0);
    check_val("exit_tick_coll", 32'(int_coll), 32'd0);
    step();
    check_val("exit_tick_hold", 32'(arb_cs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
